// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 20;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_PEND_W = 2;

    localparam int unsigned PEND_MAX   = (2 ** DEF_PEND_W) - 1;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_pend_counter.sv
// Saturating in-flight-writer counter for one register; inc and dec cancel.
module regfile_pend_counter
    import regfile_pkg::*;
#(
    parameter int unsigned PEND_W = DEF_PEND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              at_max,
    output logic              nonzero
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    assign cnt     = cnt_q;
    assign at_max  = (cnt_q == '1);
    assign nonzero = (cnt_q != '0);

    // Guards keep the count from wrapping even if a caller misbehaves.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !at_max) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed read ports, one write port and a
// per-register pending-writer scoreboard for RAW hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned PEND_W   = DEF_PEND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pending1,
    output logic              rd_pending2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ok,
    output logic              wb_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [PEND_W-1:0] cnt    [DEPTH];
    logic [DEPTH-1:0]  at_max;
    logic [DEPTH-1:0]  nonzero;
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  dec;
    logic [ADDR_W-1:0] rd_addr [2];
    logic              wr_zero;
    logic              iss_zero;
    logic              wr_live;
    logic              wb_err_q;

    assign wr_zero  = ZR && (wr_addr == '0);
    assign iss_zero = ZR && (issue_addr == '0);
    assign wr_live  = wr_en && !wr_zero;

    // A same-cycle writeback to the issue target frees one slot.
    assign issue_ok = issue_en && (reset || iss_zero || !at_max[issue_addr]
                                   || (wr_en && (wr_addr == issue_addr)));

    for (genvar a = 0; a < DEPTH; a++) begin : g_cnt
        assign inc[a] = issue_ok && !reset && !iss_zero && (issue_addr == ADDR_W'(a));
        assign dec[a] = wr_live && (wr_addr == ADDR_W'(a)) && nonzero[a];

        regfile_pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .inc     (inc[a]),
            .dec     (dec[a]),
            .cnt     (cnt[a]),
            .at_max  (at_max[a]),
            .nonzero (nonzero[a])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Sticky flag for a writeback that no issue accounted for.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_err_q <= 1'b0;
        end else if (wr_live && !nonzero[wr_addr]) begin
            wb_err_q <= 1'b1;
        end
    end

    assign wb_err     = wb_err_q;
    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic              hit;
        logic              zero;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign hit  = wr_en && (wr_addr == rd_addr[p]);
        assign zero = ZR && (rd_addr[p] == '0);

        // Pending is reported net of a writeback landing this cycle.
        always_comb begin
            data = '0;
            pend = 1'b0;
            if (!reset && !zero) begin
                data = hit ? wr_data : regs_q[rd_addr[p]];
                pend = cnt[rd_addr[p]] > (hit ? PEND_W'(1) : PEND_W'(0));
            end
        end
    end

    assign rd_data1    = g_rd[0].data;
    assign rd_data2    = g_rd[1].data;
    assign rd_pending1 = g_rd[0].pend;
    assign rd_pending2 = g_rd[1].pend;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (ZERO_REG=1): directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a simple model.
module tb_regfile_scoreboard;

    logic        clock;
    logic        reset;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [19:0] rd_data1;
    logic [19:0] rd_data2;
    logic        rd_pending1;
    logic        rd_pending2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic        issue_ok;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [19:0] mregs [16];
    int unsigned mcnt  [16];
    bit          merr;

    regfile_scoreboard #(
        .DATA_W   (20),
        .ADDR_W   (4),
        .ZERO_REG (1),
        .PEND_W   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .rd_pending1 (rd_pending1),
        .rd_pending2 (rd_pending2),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_ok    (issue_ok),
        .wb_err      (wb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] exp_data(input logic [3:0] a);
        if (reset || a == 4'd0) return 20'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return mregs[a];
    endfunction

    function automatic logic exp_pend(input logic [3:0] a);
        int unsigned landing;
        if (reset || a == 4'd0) return 1'b0;
        landing = (wr_en && wr_addr == a) ? 1 : 0;
        return mcnt[a] > landing;
    endfunction

    function automatic logic exp_ok();
        if (!issue_en) return 1'b0;
        return reset || issue_addr == 4'd0 || mcnt[issue_addr] < 3
               || (wr_en && wr_addr == issue_addr);
    endfunction

    // Model update at each rising edge
    always @(posedge clock) begin
        bit ok_inc;
        bit do_dec;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mregs[i] = 20'd0;
                mcnt[i]  = 0;
            end
            merr = 1'b0;
        end else begin
            ok_inc = exp_ok() && issue_addr != 4'd0;
            do_dec = wr_en && wr_addr != 4'd0 && mcnt[wr_addr] != 0;
            if (wr_en && wr_addr != 4'd0) begin
                if (mcnt[wr_addr] == 0) merr = 1'b1;
                mregs[wr_addr] = wr_data;
            end
            if (do_dec) mcnt[wr_addr] = mcnt[wr_addr] - 1;
            if (ok_inc) mcnt[issue_addr] = mcnt[issue_addr] + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_data1", 32'(rd_data1), 32'(exp_data(rd_addr1)));
            chk("m_data2", 32'(rd_data2), 32'(exp_data(rd_addr2)));
            chk("m_pend1", 32'(rd_pending1), 32'(exp_pend(rd_addr1)));
            chk("m_pend2", 32'(rd_pending2), 32'(exp_pend(rd_addr2)));
            chk("m_issue_ok", 32'(issue_ok), 32'(exp_ok()));
            chk("m_wb_err", 32'(wb_err), 32'(merr));
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [3:0] wa,
                         input logic [19:0] wd, input logic ie, input logic [3:0] ia,
                         input logic [3:0] a1, input logic [3:0] a2);
        reset      = rst;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        rd_addr1   = a1;
        rd_addr2   = a2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1, 1, 4'd4, 20'h55555, 1, 4'd4, 4'd4, 4'd0);
        tick();
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_data1", 32'(rd_data1), 32'h0);
        chk("rst_issue_ok", 32'(issue_ok), 32'h1);
        chk("rst_wb_err", 32'(wb_err), 32'h0);
        tick();

        // Write r1 with same-cycle bypass, then registered read
        drive(0, 1, 4'd1, 20'h00001, 0, 4'd0, 4'd1, 4'd0);
        @(negedge clock);
        chk("bypass_r1", 32'(rd_data1), 32'h00001);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd1, 4'd0);
        @(negedge clock);
        chk("reg_r1", 32'(rd_data1), 32'h00001);
        chk("reg_r0", 32'(rd_data2), 32'h0);
        chk("r1_err", 32'(wb_err), 32'h1);
        tick();

        // Reset again so the pending tests start clean
        drive(1, 0, 4'd0, 20'h0, 0, 4'd0, 4'd0, 4'd0);
        tick();

        // Issue r3, observe pending, then writeback clears it
        drive(0, 0, 4'd0, 20'h0, 1, 4'd3, 4'd3, 4'd3);
        @(negedge clock);
        chk("iss3_pend_c0", 32'(rd_pending1), 32'h0);
        chk("iss3_ok", 32'(issue_ok), 32'h1);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd3, 4'd3);
        @(negedge clock);
        chk("iss3_pend_c1", 32'(rd_pending1), 32'h1);
        tick();
        drive(0, 1, 4'd3, 20'h00AAA, 0, 4'd0, 4'd3, 4'd3);
        @(negedge clock);
        chk("wb3_pend", 32'(rd_pending1), 32'h0);
        chk("wb3_data", 32'(rd_data1), 32'h00AAA);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd3, 4'd3);
        @(negedge clock);
        chk("wb3_noerr", 32'(wb_err), 32'h0);
        tick();

        // Saturate r5, reject fourth issue, accept when a writeback frees a slot
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 4'd0, 20'h0, 1, 4'd5, 4'd5, 4'd0);
            @(negedge clock);
            chk("iss5_ok", 32'(issue_ok), 32'h1);
            tick();
        end
        drive(0, 0, 4'd0, 20'h0, 1, 4'd5, 4'd5, 4'd0);
        @(negedge clock);
        chk("iss5_full", 32'(issue_ok), 32'h0);
        tick();
        drive(0, 1, 4'd5, 20'h00555, 1, 4'd5, 4'd5, 4'd0);
        @(negedge clock);
        chk("iss5_retry_ok", 32'(issue_ok), 32'h1);
        chk("iss5_pend_net", 32'(rd_pending1), 32'h1);
        tick();
        drive(0, 0, 4'd0, 20'h0, 1, 4'd5, 4'd5, 4'd0);
        @(negedge clock);
        chk("iss5_still_full", 32'(issue_ok), 32'h0);
        chk("iss5_noerr", 32'(wb_err), 32'h0);
        tick();

        // Unsolicited write to r7 sets sticky wb_err
        drive(0, 1, 4'd7, 20'h00777, 0, 4'd0, 4'd7, 4'd0);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd7, 4'd0);
        @(negedge clock);
        chk("r7_data", 32'(rd_data1), 32'h00777);
        chk("r7_err", 32'(wb_err), 32'h1);
        tick();
        drive(0, 1, 4'd2, 20'hFFFFF, 1, 4'd2, 4'd2, 4'd7);
        tick();
        drive(0, 0, 4'd0, 20'h0, 1, 4'd2, 4'd2, 4'd7);
        @(negedge clock);
        chk("err_sticky", 32'(wb_err), 32'h1);
        tick();

        // r2 now holds FFFFF with two pending; reset with traffic active
        drive(1, 1, 4'd2, 20'h0F0F0, 1, 4'd2, 4'd2, 4'd5);
        @(negedge clock);
        chk("rst_act_ok", 32'(issue_ok), 32'h1);
        chk("rst_act_data", 32'(rd_data1), 32'h0);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd2, 4'd5);
        @(negedge clock);
        chk("post_rst_r2", 32'(rd_data1), 32'h0);
        chk("post_rst_pend", 32'(rd_pending1), 32'h0);
        chk("post_rst_pend5", 32'(rd_pending2), 32'h0);
        chk("post_rst_err", 32'(wb_err), 32'h0);
        tick();

        // Register zero ignores writes and issues
        drive(0, 1, 4'd0, 20'h12345, 1, 4'd0, 4'd0, 4'd0);
        @(negedge clock);
        chk("z_data", 32'(rd_data1), 32'h0);
        chk("z_pend", 32'(rd_pending1), 32'h0);
        chk("z_ok", 32'(issue_ok), 32'h1);
        tick();
        drive(0, 0, 4'd0, 20'h0, 0, 4'd0, 4'd0, 4'd0);
        @(negedge clock);
        chk("z_data_after", 32'(rd_data1), 32'h0);
        chk("z_err", 32'(wb_err), 32'h0);
        tick();

        // Randomized traffic, biased to a few addresses to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] wa;
            logic [3:0] ia;
            logic [3:0] a1;
            logic [3:0] a2;
            wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ia = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 1) == 0) ? ia : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), wa,
                  20'($urandom), ($urandom_range(0, 1) == 0), ia, a1, a2);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
